// File: rtl/lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_bus_arbiter
//
// Shares one write-only HD44780-style LCD bus between two clients. A request
// seen in IDLE is granted round-robin; the winner's rs/data are latched onto
// the bus, then the enable strobe is sequenced (setup, E-high, hold) and the
// controller waits for the LCD to execute the instruction before signalling
// completion with a one-cycle done pulse.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous reset, active low
//   req0/req1      : write request from client 0/1 (sampled only in IDLE)
//   rs0/rs1        : register select of the request (0 = command, 1 = data)
//   data0/data1    : byte to write
//   gnt0/gnt1      : client owns the bus (first SETUP cycle through DONE)
//   done0/done1    : one-cycle completion pulse for the owning client
//   lcd_e          : LCD enable strobe
//   lcd_rs         : LCD register select
//   lcd_rw         : LCD read/write, constant 0 (write-only)
//   lcd_db         : LCD data bus
//   busy           : high whenever the controller is not IDLE
// -----------------------------------------------------------------------------
module lcd_bus_arbiter #(
    parameter int SETUP_CYC     = 2,
    parameter int E_HIGH_CYC    = 12,
    parameter int HOLD_CYC      = 2,
    parameter int WAIT_DATA_CYC = 2000,
    parameter int WAIT_CLR_CYC  = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db,
    output logic       busy
);

    localparam int CNT_W = 17;

    // Counter reload values: each timed state runs until the counter hits 0,
    // so a state lasting K cycles is loaded with K-1.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] DATA_LD  = CNT_W'(WAIT_DATA_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(WAIT_CLR_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last1;     // 1 = client 1 was served last
    logic             pick1;     // arbitration result for this cycle
    logic             clear_cmd; // latched byte is clear display / return home

    // Client 1 wins when it is the only requester, or on a tie when client 0
    // was served last.
    assign pick1 = req1 & (~req0 | ~last1);

    // Clear (0x01) and return home (0x02/0x03) need the long execution wait.
    assign clear_cmd = ~lcd_rs & (lcd_db[7:2] == 6'd0);

    assign lcd_rw = 1'b0;

    // NOTE: every register here, including the bus latches, is cleared by the
    // synchronous reset so an interrupted transaction leaves no trace; all
    // state updates use non-blocking assignments so the case arms read the
    // pre-edge values consistently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last1  <= 1'b1;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_db <= 8'h00;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state  <= SETUP;
                        cnt    <= SETUP_LD;
                        busy   <= 1'b1;
                        gnt0   <= ~pick1;
                        gnt1   <= pick1;
                        last1  <= pick1;
                        lcd_rs <= pick1 ? rs1 : rs0;
                        lcd_db <= pick1 ? data1 : data0;
                    end
                end

                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= E_LD;
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                STROBE: begin
                    if (cnt == '0) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                HOLD: begin
                    if (cnt == '0) begin
                        state <= WAIT;
                        cnt   <= clear_cmd ? CLR_LD : DATA_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                WAIT: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        done0 <= gnt0;
                        done1 <= gnt1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    // Release the bus; lcd_rs/lcd_db keep their last values.
                    state <= IDLE;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_arbiter
//
// Directed bench for lcd_bus_arbiter with SETUP=2, E_HIGH=3, HOLD=2,
// WAIT_DATA=5, WAIT_CLR=10. For a request presented in cycle t0 the expected
// timeline is: gnt from t0+1, lcd_e rising in t0+3 for 3 cycles, done in
// t0+13 (normal write) or t0+18 (clear/home). Stimulus pushes expected grant,
// strobe and done events into queues; a monitor on the falling edge pops and
// compares them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_lcd_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       gnt0, gnt1, done0, done1, lcd_e, lcd_rs, lcd_rw, busy;
    logic [7:0] lcd_db;

    lcd_bus_arbiter #(
        .SETUP_CYC    (2),
        .E_HIGH_CYC   (3),
        .HOLD_CYC     (2),
        .WAIT_DATA_CYC(5),
        .WAIT_CLR_CYC (10)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .rs0   (rs0),
        .rs1   (rs1),
        .data0 (data0),
        .data1 (data1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .lcd_e (lcd_e),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_db(lcd_db),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int   cyc;
        logic client;
    } gnt_exp_t;

    typedef struct {
        int         cyc;
        logic       client;
        logic       rs;
        logic [7:0] db;
    } done_exp_t;

    gnt_exp_t  gnt_q[$];
    int        e_q[$];
    done_exp_t done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Advance to the drive point (#1 after the rising edge) of cycle c.
    task automatic drive_at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance to the falling edge inside cycle c.
    task automatic sample_at(input int c);
        drive_at(c);
        @(negedge clk);
    endtask

    // One write from a single client; req is held for exactly one cycle.
    task automatic run_write(input logic client, input logic rs, input logic [7:0] db,
                             input int done_off, output int t0);
        @(posedge clk);
        #1;
        t0 = cyc;
        if (client) begin
            req1 = 1'b1; rs1 = rs; data1 = db;
        end else begin
            req0 = 1'b1; rs0 = rs; data0 = db;
        end
        gnt_q.push_back('{t0 + 1, client});
        e_q.push_back(t0 + 3);
        done_q.push_back('{t0 + done_off, client, rs, db});
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // ---------------------------------------------------------------- monitor
    logic pg0 = 1'b0, pg1 = 1'b0, pe = 1'b0;
    int   e_width = 0;

    always @(negedge clk) begin
        if (gnt0 && gnt1) check("gnt_overlap", 32'd1, 32'd0);

        if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
            if (gnt_q.size() == 0) begin
                check("gnt_unexpected", 32'd1, 32'd0);
            end else begin
                gnt_exp_t g;
                g = gnt_q.pop_front();
                check("gnt_cycle", cyc, g.cyc);
                check("gnt_client", {31'd0, gnt1}, {31'd0, g.client});
            end
        end

        if (lcd_e && !pe) begin
            e_width = 0;
            if (e_q.size() == 0) begin
                check("e_unexpected", 32'd1, 32'd0);
            end else begin
                int ec;
                ec = e_q.pop_front();
                check("e_rise_cycle", cyc, ec);
            end
        end
        if (lcd_e) e_width++;
        if (!lcd_e && pe && rst) check("e_width", e_width, 32'd3);

        if (done0 || done1) begin
            check("done_both", {31'd0, done0 & done1}, 32'd0);
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                check("done_cycle", cyc, d.cyc);
                check("done_client", {31'd0, done1}, {31'd0, d.client});
                check("done_db", {24'd0, lcd_db}, {24'd0, d.db});
                check("done_rs", {31'd0, lcd_rs}, {31'd0, d.rs});
                check("done_gnt_held", {31'd0, d.client ? gnt1 : gnt0}, 32'd1);
            end
        end

        pg0 = gnt0;
        pg1 = gnt1;
        pe  = lcd_e;
    end

    // ---------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int t0;
        int t1;

        // Reset state.
        sample_at(3);
        check("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check("rst_gnt1", {31'd0, gnt1}, 32'd0);
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        check("rst_lcd_db", {24'd0, lcd_db}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        drive_at(4);
        rst = 1'b1;

        // Single data write 0x41: done at t0+13, busy over t0+1..t0+13.
        run_write(1'b0, 1'b1, 8'h41, 13, t0);
        sample_at(t0 + 1);
        check("w1_busy_start", {31'd0, busy}, 32'd1);
        check("w1_db", {24'd0, lcd_db}, 32'h41);
        check("w1_rs", {31'd0, lcd_rs}, 32'd1);
        sample_at(t0 + 4);
        check("w1_lcd_e_mid", {31'd0, lcd_e}, 32'd1);
        check("w1_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        sample_at(t0 + 13);
        check("w1_busy_done", {31'd0, busy}, 32'd1);
        sample_at(t0 + 14);
        check("w1_busy_idle", {31'd0, busy}, 32'd0);
        check("w1_db_held", {24'd0, lcd_db}, 32'h41);
        drive_at(t0 + 15);

        // Command decoding for the execution wait.
        run_write(1'b0, 1'b0, 8'h01, 18, t0);  // clear display: long wait
        drive_at(t0 + 20);
        run_write(1'b0, 1'b0, 8'h38, 13, t0);  // function set: short wait
        drive_at(t0 + 15);
        run_write(1'b1, 1'b0, 8'h03, 18, t0);  // return home (upper edge)
        drive_at(t0 + 20);
        run_write(1'b1, 1'b0, 8'h04, 13, t0);  // first non-home command
        drive_at(t0 + 15);
        run_write(1'b0, 1'b1, 8'h01, 13, t0);  // data 0x01 is a normal write
        drive_at(t0 + 15);

        // Dropped request: rs/data/req change during STROBE are ignored.
        @(posedge clk);
        #1;
        t0 = cyc;
        req1 = 1'b1; rs1 = 1'b0; data1 = 8'h38;
        gnt_q.push_back('{t0 + 1, 1'b1});
        e_q.push_back(t0 + 3);
        done_q.push_back('{t0 + 13, 1'b1, 1'b0, 8'h38});
        drive_at(t0 + 4);
        req1 = 1'b0; rs1 = 1'b1; data1 = 8'h01;
        sample_at(t0 + 6);
        check("drop_db", {24'd0, lcd_db}, 32'h38);
        check("drop_rs", {31'd0, lcd_rs}, 32'd0);
        drive_at(t0 + 15);

        // Tie from reset release: 0, 1, 0, one idle cycle between owners.
        rst = 1'b0;
        drive_at(cyc + 2);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h30;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h31;
        drive_at(cyc + 1);
        rst = 1'b1;
        t0 = cyc;
        gnt_q.push_back('{t0 + 1, 1'b0});
        e_q.push_back(t0 + 3);
        done_q.push_back('{t0 + 13, 1'b0, 1'b1, 8'h30});
        gnt_q.push_back('{t0 + 15, 1'b1});
        e_q.push_back(t0 + 17);
        done_q.push_back('{t0 + 27, 1'b1, 1'b1, 8'h31});
        gnt_q.push_back('{t0 + 29, 1'b0});
        e_q.push_back(t0 + 31);
        done_q.push_back('{t0 + 41, 1'b0, 1'b1, 8'h30});
        sample_at(t0 + 14);
        check("tie_idle_gap", {31'd0, busy}, 32'd0);
        drive_at(t0 + 30);
        req0 = 1'b0;
        req1 = 1'b0;
        drive_at(t0 + 43);

        // Reset mid-strobe of a client-0 write; no done, then a tie goes to 0.
        @(posedge clk);
        #1;
        t0 = cyc;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h66;
        gnt_q.push_back('{t0 + 1, 1'b0});
        e_q.push_back(t0 + 3);
        drive_at(t0 + 1);
        req0 = 1'b0;
        drive_at(t0 + 4);
        rst = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h77;
        @(negedge clk);
        check("mid_lcd_e_before", {31'd0, lcd_e}, 32'd1);
        sample_at(t0 + 5);
        check("mid_lcd_e", {31'd0, lcd_e}, 32'd0);
        check("mid_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_lcd_db", {24'd0, lcd_db}, 32'h00);
        check("mid_lcd_rs", {31'd0, lcd_rs}, 32'd0);
        drive_at(t0 + 6);
        rst = 1'b1;
        t1 = cyc;
        gnt_q.push_back('{t1 + 1, 1'b0});
        e_q.push_back(t1 + 3);
        done_q.push_back('{t1 + 13, 1'b0, 1'b1, 8'h66});
        drive_at(t1 + 2);
        req0 = 1'b0;
        req1 = 1'b0;
        drive_at(t1 + 16);

        // Every expected event must have been observed.
        check("gnt_q_drained", gnt_q.size(), 32'd0);
        check("e_q_drained", e_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
